sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2, range 1..15; cycles per 16-bit SRAM half-access.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port mem_r_en  input  1  MEM-stage load request.
REQ-005 SHALL have port mem_w_en  input  1  MEM-stage store request.
REQ-006 SHALL have port address  input  32  byte address; bits [18:2] select the word.
REQ-007 SHALL have port wdata  input  32  store data.
REQ-008 SHALL have port rdata  output  32  load data, registered.
REQ-009 SHALL have port ready  output  1  low means freeze pipeline; combinational from state and requests.
REQ-010 SHALL have port sram_addr  output  18  SRAM half-word address.
REQ-011 SHALL have port sram_dq_out  output  16  SRAM write data.
REQ-012 SHALL have port sram_dq_oe  output  1  SRAM data bus drive enable.
REQ-013 SHALL have port sram_dq_in  input  16  SRAM read data.
REQ-014 SHALL have ports sram_ce_n, sram_we_n, sram_oe_n  output  1 each  active-low SRAM strobes.

Function
REQ-015 SHALL implement FSM with states IDLE, LOW, HIGH, DONE and a 4-bit phase counter.
REQ-016 IDLE with mem_r_en or mem_w_en high SHALL latch address[18:2], wdata and the op, then go to LOW with counter 0.
REQ-017 mem_r_en and mem_w_en both high SHALL be treated as a read; the write is dropped.
REQ-018 LOW and HIGH SHALL each last exactly PHASE_CYCLES cycles, then go to HIGH and DONE respectively.
REQ-019 DONE SHALL last one cycle and then go to IDLE; no new request is accepted in DONE.
REQ-020 sram_addr SHALL be {latched_word, 0} in LOW, {latched_word, 1} in HIGH, and hold its last value otherwise.
REQ-021 sram_ce_n SHALL be 0 in LOW/HIGH and 1 otherwise; sram_we_n 0 and sram_dq_oe 1 in LOW/HIGH for writes; sram_oe_n 0 in LOW/HIGH for reads.
REQ-022 sram_dq_out SHALL be wdata[15:0] in LOW and wdata[31:16] in HIGH (latched values).
REQ-023 For reads, sram_dq_in SHALL be captured into rdata[15:0] on the last LOW cycle and into rdata[31:16] on the last HIGH cycle.
REQ-024 rdata SHALL hold until the next read capture; writes SHALL leave it unchanged.
REQ-025 ready SHALL be 0 when (mem_r_en or mem_w_en) and state is not DONE; otherwise 1.
REQ-026 Load latency: request in IDLE at cycle 0 gives ready 0 for cycles 0..2*PHASE_CYCLES and ready 1 in cycle 2*PHASE_CYCLES+1 with valid rdata.
REQ-027 A request deasserted mid-operation SHALL NOT abort the access; the FSM completes through DONE.

Reset
REQ-028 rst low SHALL immediately force IDLE, counter 0, rdata 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, and sram_ce_n, sram_we_n and sram_oe_n all 1.
REQ-029 Reset mid-access SHALL abandon the access with no further SRAM strobes; ready then follows REQ-025 from IDLE.

Configuration
REQ-030 Macro WRITE_POST_EN SHALL, when defined, make ready 1 in an IDLE cycle accepting a write-only request, so the pipeline advances while the write drains.
REQ-031 With WRITE_POST_EN, a posted write SHALL go HIGH to IDLE and skip DONE; requests seen during LOW/HIGH get ready 0 until IDLE.
REQ-032 Without WRITE_POST_EN, writes SHALL behave exactly like reads for ready and DONE timing.

Verification
REQ-033 Load, PHASE_CYCLES=2: address 0x0000_0010 with SRAM half-words 0x1234 (addr 8) and 0xABCD (addr 9) -> ready low cycles 0..4, high cycle 5, rdata 0xABCD1234.
REQ-034 Store of 0xDEADBEEF to 0x0000_0020, macro undefined -> sram_addr 16 with dq 0xBEEF and we_n 0, then 17 with 0xDEAD; ready high cycle 5.
REQ-035 Same store with WRITE_POST_EN, followed by a load the next cycle -> ready 1 in cycle 0; load ready low until the write reaches IDLE, then full load latency.
REQ-036 mem_r_en and mem_w_en both high -> sram_we_n stays 1 and rdata updates.
REQ-037 rst low in cycle 2 of a load -> strobes high and FSM in IDLE at once; rdata 0.
REQ-038 PHASE_CYCLES=1 back-to-back loads with the request held -> DONE for one cycle, next access starts from IDLE, each load's ready-low window 3 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port onto a 16-bit async SRAM in two half-word phases; optional posted writes via `define WRITE_POST_EN
module sram_controller #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [3:0]  cnt;
  logic [16:0] word;
  logic [31:0] wd;
  logic        op_wr;

  logic        req;
  logic        take;
  logic        take_wr;
  logic        phase_end;
  logic        in_access_nx;
  logic [16:0] word_nx;
  logic [31:0] wd_nx;
  logic        op_wr_nx;

  // Only address[18:2] selects a word; the rest of the byte address is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  // A simultaneous read and write request is a read; the write is dropped.
  assign req       = mem_r_en | mem_w_en;
  assign take      = (state == IDLE) && req;
  assign take_wr   = mem_w_en & ~mem_r_en;
  assign phase_end = (cnt == LAST_CNT);

  // Values that will be latched at this edge, so strobes and address line up with the state they belong to.
  assign word_nx      = take ? address[18:2] : word;
  assign wd_nx        = take ? wdata : wd;
  assign op_wr_nx     = take ? take_wr : op_wr;
  assign in_access_nx = (state_nx == LOW) || (state_nx == HIGH);

  // Next-state logic: IDLE -> LOW -> HIGH -> DONE -> IDLE (posted writes leave from HIGH).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = LOW;
      LOW:  if (phase_end) state_nx = HIGH;
      HIGH: begin
        if (phase_end) begin
`ifdef WRITE_POST_EN
          state_nx = op_wr ? IDLE : DONE;
`else
          state_nx = DONE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pipeline freeze: any request holds the pipe until DONE (a write-only request in IDLE is let through when posting).
  always_comb begin
    ready = 1'b1;
    if (req && (state != DONE)) ready = 1'b0;
`ifdef WRITE_POST_EN
    if ((state == IDLE) && take_wr) ready = 1'b1;
`endif
  end

  // State, phase counter and request latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      word  <= 17'd0;
      wd    <= 32'd0;
      op_wr <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state_nx == state) && ((state == LOW) || (state == HIGH))) cnt <= cnt + 4'd1;
      else cnt <= 4'd0;
      if (take) begin
        word  <= address[18:2];
        wd    <= wdata;
        op_wr <= take_wr;
      end
    end
  end

  // Registered SRAM pins, driven for the state being entered so they are clean for the whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      sram_ce_n  <= ~in_access_nx;
      sram_we_n  <= ~(in_access_nx & op_wr_nx);
      sram_dq_oe <= in_access_nx & op_wr_nx;
      sram_oe_n  <= ~(in_access_nx & ~op_wr_nx);
      if (state_nx == LOW) begin
        sram_addr   <= {word_nx, 1'b0};
        sram_dq_out <= wd_nx[15:0];
      end else if (state_nx == HIGH) begin
        sram_addr   <= {word_nx, 1'b1};
        sram_dq_out <= wd_nx[31:16];
      end
    end
  end

  // Read capture on the last cycle of each phase; writes never touch rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (!op_wr && phase_end) begin
      if (state == LOW)  rdata[15:0]  <= sram_dq_in;
      if (state == HIGH) rdata[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed vector bench for sram_controller with a behavioural SRAM model
`timescale 1ns/1ps
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en, w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, ce_n, we_n, oe_n;

  logic        r_en_1, w_en_1;
  logic [31:0] address_1, wdata_1, rdata_1;
  logic        ready_1;
  logic [17:0] sram_addr_1;
  logic [15:0] dq_out_1, dq_in_1;
  logic        dq_oe_1, ce_n_1, we_n_1, oe_n_1;

  int vec_count = 0;
  int errs = 0;

  sram_controller #(.PHASE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe),
    .sram_dq_in(dq_in), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n));

  sram_controller #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en_1), .mem_w_en(w_en_1), .address(address_1), .wdata(wdata_1),
    .rdata(rdata_1), .ready(ready_1), .sram_addr(sram_addr_1), .sram_dq_out(dq_out_1), .sram_dq_oe(dq_oe_1),
    .sram_dq_in(dq_in_1), .sram_ce_n(ce_n_1), .sram_we_n(we_n_1), .sram_oe_n(oe_n_1));

  // SRAM model for the main instance: 256 half-words, async read, write on strobe.
  logic [15:0] mem [0:255];
  logic        init_mem;
  assign dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0101);
      mem[8] <= 16'h1234;
      mem[9] <= 16'hABCD;
    end else if (!ce_n && !we_n) begin
      mem[sram_addr[7:0]] <= dq_out;
    end
  end

  // Second instance reads a pattern derived from the half-word address.
  assign dq_in_1 = sram_addr_1[15:0] ^ 16'hA5A5;

  function automatic logic [31:0] pat_word(input logic [16:0] w);
    logic [17:0] lo, hi;
    lo = {w, 1'b0};
    hi = {w, 1'b1};
    return {hi[15:0] ^ 16'hA5A5, lo[15:0] ^ 16'hA5A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef WRITE_POST_EN
  localparam int WR_LOW = 0;
`else
  localparam int WR_LOW = 5;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    int          exp_low;
    int          exp_we;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, cec, wec, ok;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hABCD_1234, 5,      0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF,  32'hABCD_1234, WR_LOW, 4};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hDEAD_BEEF, 5,      0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555,  32'hABCD_1234, 5,      0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hABCD_1234, 5,      0};
    vecs[5] = '{1'b0, 1'b1, 32'h0007_FFFC, 32'h0F0F_F0F0,  32'hABCD_1234, WR_LOW, 4};
    vecs[6] = '{1'b1, 1'b0, 32'h0007_FFFC, 32'h0,          32'h0F0F_F0F0, 5,      0};
    vecs[7] = '{1'b1, 1'b0, 32'hFFF8_0020, 32'h0,          32'hDEAD_BEEF, 5,      0};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0101_0000, 5,      0};

    rst = 1'b0; init_mem = 1'b1;
    r_en = 0; w_en = 0; address = 0; wdata = 0;
    r_en_1 = 0; w_en_1 = 0; address_1 = 0; wdata_1 = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_rdata", rdata, 0);
    check("reset_strobes", {ce_n, we_n, oe_n, dq_oe}, 4'b1110);
    check("reset_addr", sram_addr, 0);
    check("reset_dq_out", dq_out, 0);
    check("reset_rdata_p1", rdata_1, 0);
    @(negedge clk);
    rst = 1'b1; init_mem = 1'b0;

    // Table of single accesses: latency, data, and strobe activity per access.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      r_en = vecs[v].rd; w_en = vecs[v].wr; address = vecs[v].addr; wdata = vecs[v].wd;
      lowc = 0; cec = 0; wec = 0; ok = 0;
      for (int c = 0; c < 20 && ok == 0; c++) begin
        #1;
        if (!ce_n) cec++;
        if (!we_n) wec++;
        if (ready) ok = 1;
        else begin
          lowc++;
          @(negedge clk);
        end
      end
      @(posedge clk);
      #1;
      r_en = 0; w_en = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        #1;
        if (!ce_n) cec++;
        if (!we_n) wec++;
      end
      check($sformatf("vec%0d_ready_low", v), lowc, vecs[v].exp_low);
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_ce_cycles", v), cec, 4);
      check($sformatf("vec%0d_we_cycles", v), wec, vecs[v].exp_we);
    end

`ifndef WRITE_POST_EN
    // Store 0xDEADBEEF to 0x20 cycle by cycle: half-words 16/17, low half first.
    begin
      logic [17:0] ea [4];
      logic [15:0] ed [4];
      ea = '{18'd16, 18'd16, 18'd17, 18'd17};
      ed = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
      @(negedge clk);
      w_en = 1; address = 32'h20; wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 6; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        check($sformatf("store_c%0d_ready", c), ready, (c == 5) ? 1 : 0);
        check($sformatf("store_c%0d_ce_we", c), {ce_n, we_n}, (c >= 1 && c <= 4) ? 2'b00 : 2'b11);
        if (c >= 1 && c <= 4) begin
          check($sformatf("store_c%0d_addr", c), sram_addr, ea[c-1]);
          check($sformatf("store_c%0d_dq", c), {dq_oe, dq_out}, {1'b1, ed[c-1]});
        end
      end
      @(posedge clk);
      #1;
      w_en = 0;
      repeat (2) @(negedge clk);
    end
`else
    // Posted store followed by a load the next cycle.
    @(negedge clk);
    w_en = 1; address = 32'h20; wdata = 32'hCAFE_F00D;
    #1;
    check("posted_ready_c0", ready, 1);
    @(posedge clk);
    #1;
    w_en = 0; r_en = 1; address = 32'h20;
    lowc = 0; ok = 0;
    for (int c = 0; c < 30 && ok == 0; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) check("posted_we_c1", we_n, 0);
      if (ready) ok = 1;
      else lowc++;
    end
    @(posedge clk);
    #1;
    r_en = 0;
    check("posted_load_low", lowc, 9);
    check("posted_load_rdata", rdata, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
`endif

    // Reset in cycle 2 of a load abandons it immediately.
    @(negedge clk);
    r_en = 1; address = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_pre_ce", ce_n, 0);
    rst = 1'b0;
    #1;
    check("midrst_strobes", {ce_n, we_n, oe_n, dq_oe}, 4'b1110);
    check("midrst_rdata", rdata, 0);
    check("midrst_ready_req", ready, 0);
    r_en = 0;
    #1;
    check("midrst_ready_idle", ready, 1);
    @(negedge clk);
    rst = 1'b1;
    cec = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (!ce_n) cec++;
    end
    check("midrst_no_strobes", cec, 0);

    // PHASE_CYCLES=1, request held across three back-to-back loads.
    @(negedge clk);
    r_en_1 = 1; address_1 = 32'h4;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("p1_c%0d_ready", c), ready_1, (c % 4 == 3) ? 1 : 0);
      if (c % 4 == 3) begin
        check($sformatf("p1_c%0d_ce_done", c), ce_n_1, 1);
        check($sformatf("p1_c%0d_rdata", c), rdata_1, pat_word(17'(c / 4 + 1)));
        address_1 = 32'((c / 4 + 2) * 4);
      end
    end
    @(posedge clk);
    #1;
    r_en_1 = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, errs);
    $finish;
  end

endmodule
